// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, derived line/frame totals and state types for vga_timing_gen.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    function automatic int unsigned axis_total(input int unsigned act, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    localparam int unsigned H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} axis_state_t;
    typedef enum logic {IDLE, RUN} run_state_t;

    // Eight vertical bars, left to right; anything past bar 7 is black.
    function automatic logic [23:0] bar_colour(input logic [CNT_W-1:0] idx);
        logic [23:0] c;
        case (idx)
            CNT_W'(0): c = 24'hFFFFFF;
            CNT_W'(1): c = 24'hFFFF00;
            CNT_W'(2): c = 24'h00FFFF;
            CNT_W'(3): c = 24'h00FF00;
            CNT_W'(4): c = 24'hFF00FF;
            CNT_W'(5): c = 24'hFF0000;
            CNT_W'(6): c = 24'h0000FF;
            default:   c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter, terminal count and ACTIVE/FRONT/SYNC/BACK region FSM.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned N_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned N_FP     = DEF_H_FP,
    parameter int unsigned N_SYNC   = DEF_H_SYNC,
    parameter int unsigned N_BP     = DEF_H_BP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o,
    output axis_state_t      state_o
);

    localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(N_ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_AT  = CNT_W'(N_ACTIVE + N_FP);
    localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(N_ACTIVE + N_FP + N_SYNC);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(axis_total(N_ACTIVE, N_FP, N_SYNC, N_BP) - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    axis_state_t      state_q, state_d;

    assign tc_o    = (cnt_q == LAST);
    assign cnt_o   = cnt_q;
    assign state_o = state_q;

    // Region transitions look at the next count so state_q always matches cnt_q.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (clr_i) begin
            cnt_d   = '0;
            state_d = ACTIVE;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
            unique case (state_q)
                ACTIVE: if (cnt_d == FRONT_AT) state_d = FRONT;
                FRONT:  if (cnt_d == SYNC_AT)  state_d = SYNC;
                SYNC:   if (cnt_d == BACK_AT)  state_d = BACK;
                BACK:   if (tc_o)              state_d = ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            state_q <= ACTIVE;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator gated by PLL lock, with registered sync/video/position outputs.
// Define VGA_TIMING_TEST_PATTERN_EN to add the 24-bit colour-bar output rgb.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start
`ifdef VGA_TIMING_TEST_PATTERN_EN
    ,
    output logic [23:0] rgb
`endif
);

    run_state_t       state_q, state_d;
    logic             run_act;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_tc, v_tc, unused_v_tc;
    axis_state_t      h_state, v_state;

    logic       hsync_q, hsync_d, vsync_q, vsync_d;
    logic       video_q, video_d, fstart_q, fstart_d;
    logic [9:0] x_q, x_d, y_q, y_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (locked)  state_d = RUN;
            RUN:  if (!locked) state_d = IDLE;
        endcase
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Counters clear on the very edge lock drops, so a relock always restarts at (0,0).
    assign run_act = (state_q == RUN) && locked;

    vga_axis_counter #(
        .N_ACTIVE (H_ACTIVE),
        .N_FP     (H_FP),
        .N_SYNC   (H_SYNC),
        .N_BP     (H_BP)
    ) u_h_axis (
        .clk_i   (refclk),
        .rst_i   (rst),
        .clr_i   (!run_act),
        .en_i    (1'b1),
        .cnt_o   (h_cnt),
        .tc_o    (h_tc),
        .state_o (h_state)
    );

    vga_axis_counter #(
        .N_ACTIVE (V_ACTIVE),
        .N_FP     (V_FP),
        .N_SYNC   (V_SYNC),
        .N_BP     (V_BP)
    ) u_v_axis (
        .clk_i   (refclk),
        .rst_i   (rst),
        .clr_i   (!run_act),
        .en_i    (h_tc),
        .cnt_o   (v_cnt),
        .tc_o    (v_tc),
        .state_o (v_state)
    );

    assign unused_v_tc = v_tc;

    always_comb begin
        hsync_d  = ~SYNC_POL;
        vsync_d  = ~SYNC_POL;
        video_d  = 1'b0;
        fstart_d = 1'b0;
        x_d      = '0;
        y_d      = '0;
        if (run_act) begin
            if (h_state == SYNC) hsync_d = SYNC_POL;
            if (v_state == SYNC) vsync_d = SYNC_POL;
            video_d  = (h_state == ACTIVE) && (v_state == ACTIVE);
            fstart_d = (h_cnt == '0) && (v_cnt == '0);
            if (video_d) begin
                x_d = h_cnt;
                y_d = v_cnt;
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            video_q  <= 1'b0;
            fstart_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            video_q  <= video_d;
            fstart_q <= fstart_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_q;
    assign frame_start = fstart_q;
    assign x           = x_q;
    assign y           = y_q;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int unsigned      BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(BAR_W);

    logic [23:0] rgb_q, rgb_d;

    always_comb begin
        rgb_d = '0;
        if (video_d) rgb_d = bar_colour(h_cnt / BAR_W_C);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) rgb_q <= '0;
        else     rgb_q <= rgb_d;
    end

    assign rgb = rgb_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: full horizontal timing, shortened vertical axis to keep frames small.
module tb_vga_timing_gen;

    localparam int unsigned HA = 640, HFP = 16, HS = 96, HBP = 48;
    localparam int unsigned VA = 8, VFP = 1, VS = 2, VBP = 2;
    localparam int unsigned HT = HA + HFP + HS + HBP;
    localparam int unsigned VT = VA + VFP + VS + VBP;
    localparam int unsigned FRAME = HT * VT;
    localparam bit POL = 1'b0;

    logic refclk = 1'b0;
    logic rst = 1'b0;
    logic locked = 1'b0;
    logic hsync, vsync, video_on, frame_start;
    logic [9:0] x, y;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [23:0] rgb;
`endif

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_POL (POL)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .x           (x),
        .y           (y),
        .frame_start (frame_start)
`ifdef VGA_TIMING_TEST_PATTERN_EN
        ,
        .rgb         (rgb)
`endif
    );

    initial forever #5 refclk = ~refclk;

    typedef struct {
        bit          hs;
        bit          vs;
        bit          vid;
        bit          fs;
        int unsigned x;
        int unsigned y;
        logic [23:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    bit m_run = 1'b0;
    int unsigned m_pos = 0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic exp_t idle_exp();
        exp_t e;
        e.hs = !POL; e.vs = !POL; e.vid = 1'b0; e.fs = 1'b0;
        e.x = 0; e.y = 0; e.rgb = '0;
        return e;
    endfunction

    // Expected outputs for the raster position reached pos pixels after frame start.
    function automatic exp_t pixel_exp(input int unsigned pos);
        exp_t e;
        int unsigned h, v;
        h = pos % HT;
        v = pos / HT;
        e.vid = (h < HA) && (v < VA);
        e.hs  = (h >= HA + HFP && h < HA + HFP + HS) ? POL : !POL;
        e.vs  = (v >= VA + VFP && v < VA + VFP + VS) ? POL : !POL;
        e.fs  = (pos == 0);
        e.x   = e.vid ? h : 0;
        e.y   = e.vid ? v : 0;
        e.rgb = e.vid ? bars[h / (HA / 8)] : 24'h000000;
        return e;
    endfunction

    task automatic step(input bit l, input bit r);
        exp_t e;
        @(negedge refclk);
        locked = l;
        rst = r;
        if (r) begin
            e = idle_exp();
            m_run = 1'b0;
            m_pos = 0;
        end else if (m_run && l) begin
            e = pixel_exp(m_pos);
            m_pos = (m_pos + 1) % FRAME;
        end else begin
            e = idle_exp();
            m_pos = 0;
            m_run = l;
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)", name, got, got, expv, expv);
        end
    endtask

    function automatic logic [31:0] idle_vec();
        return 32'({!POL, !POL, 1'b0, 1'b0, 10'd0, 10'd0});
    endfunction

    // Monitor: every clock presents a registered output set; pop and compare.
    initial begin
        exp_t e;
        bit ok;
        logic [23:0] got_rgb;
        forever begin
            @(posedge refclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got_rgb = e.rgb;
`ifdef VGA_TIMING_TEST_PATTERN_EN
                got_rgb = rgb;
`endif
                ok = (hsync === e.hs) && (vsync === e.vs) && (video_on === e.vid) &&
                     (frame_start === e.fs) && (x === 10'(e.x)) && (y === 10'(e.y)) &&
                     (got_rgb === e.rgb);
                n_checks++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got hs=%b vs=%b vid=%b fs=%b x=%0d y=%0d rgb=%h, required hs=%b vs=%b vid=%b fs=%b x=%0d y=%0d rgb=%h",
                             $time, hsync, vsync, video_on, frame_start, x, y, got_rgb,
                             e.hs, e.vs, e.vid, e.fs, e.x, e.y, e.rgb);
                end
            end
        end
    end

    // Free-running measurements of the first locked run.
    bit meas_en = 1'b0;
    int cyc = 0, first_vid = -1, first_hs = -1, second_hs = -1, hs_w = -1;
    int first_vs = -1, vs_w = -1, fs1 = -1, fs2 = -1, vid_cnt = 0, xmax = -1, ymax = -1;
    logic hs_prev = 1'b1, vs_prev = 1'b1;

    initial forever begin
        @(posedge refclk);
        #1;
        if (meas_en) begin
            cyc++;
            if (video_on === 1'b1 && first_vid < 0) first_vid = cyc;
            if (hsync === POL && hs_prev === !POL) begin
                if (first_hs < 0) first_hs = cyc;
                else if (second_hs < 0) second_hs = cyc;
            end
            if (hsync === !POL && hs_prev === POL && first_hs >= 0 && hs_w < 0) hs_w = cyc - first_hs;
            if (vsync === POL && vs_prev === !POL && first_vs < 0) first_vs = cyc;
            if (vsync === !POL && vs_prev === POL && first_vs >= 0 && vs_w < 0) vs_w = cyc - first_vs;
            if (frame_start === 1'b1) begin
                if (fs1 < 0) fs1 = cyc;
                else if (fs2 < 0) fs2 = cyc;
            end
            if (video_on === 1'b1 && fs1 >= 0 && fs2 < 0) vid_cnt++;
            if (video_on === 1'b1 && int'(x) > xmax) xmax = int'(x);
            if (video_on === 1'b1 && int'(y) > ymax) ymax = int'(y);
            hs_prev = hsync;
            vs_prev = vsync;
        end
    end

    initial begin
        int unsigned guard;
        #1;
        rst = 1'b1;
        #1;
        chk("reset_async_outputs", 32'({hsync, vsync, video_on, frame_start, x, y}), idle_vec());
`ifdef VGA_TIMING_TEST_PATTERN_EN
        chk("reset_async_rgb", 32'(rgb), 32'd0);
`endif
        repeat (4) step(1'($urandom_range(0, 1)), 1'b1);
        repeat ($urandom_range(3, 10)) step(1'b0, 1'b0);

        meas_en = 1'b1;
        repeat (3 * FRAME + 20) step(1'b1, 1'b0);
        meas_en = 1'b0;
        chk("first_hsync_after_video", 32'(first_hs - first_vid), HA + HFP);
        chk("hsync_width", 32'(hs_w), HS);
        chk("line_period", 32'(second_hs - first_hs), HT);
        chk("frame_start_period", 32'(fs2 - fs1), FRAME);
        chk("vsync_width", 32'(vs_w), VS * HT);
        chk("video_on_cycles", 32'(vid_cnt), HA * VA);
        chk("x_max", 32'(xmax), HA - 1);
        chk("y_max", 32'(ymax), VA - 1);

        // Drop lock just after pixel (320,5) is displayed, then relock.
        guard = 0;
        while (m_pos != 5 * HT + 321 && guard < 2 * FRAME) begin
            step(1'b1, 1'b0);
            guard++;
        end
        chk("lock_drop_point_reached", 32'(m_pos), 5 * HT + 321);
        step(1'b0, 1'b0);
        repeat ($urandom_range(2, 20)) step(1'b0, 1'b0);
        repeat (2 * HT) step(1'b1, 1'b0);

        repeat (3000) step($urandom_range(0, 49) != 0, 1'b0);

        // Asynchronous reset in the middle of a line, between clock edges.
        guard = 0;
        while ((!m_run || m_pos % HT != 300) && guard < 2 * FRAME) begin
            step(1'b1, 1'b0);
            guard++;
        end
        #8;
        rst = 1'b1;
        m_run = 1'b0;
        m_pos = 0;
        #1;
        chk("reset_midline_outputs", 32'({hsync, vsync, video_on, frame_start, x, y}), idle_vec());
`ifdef VGA_TIMING_TEST_PATTERN_EN
        chk("reset_midline_rgb", 32'(rgb), 32'd0);
`endif
        repeat (3) step(1'b1, 1'b1);
        repeat (2 * HT + 100) step(1'b1, 1'b0);

        repeat (2) @(negedge refclk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
